// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer: byte-to-nibble writer for a 4-bit HD44780-style LCD bus.
// Latency: accept to first LCD_E rise = 1 + P_SETUP cycles; accept to next oReady =
//   1 + 2*P_SETUP + 2*P_E_HIGH + P_NIB_GAP + (P_CMD_WAIT or P_CLEAR_WAIT).
// Backpressure: oReady is high only when idle; iReq while oReady=0 is dropped (no queue).
//
// Optional build macro LCD_CONFIG_SEQ_EN: after init done, issue 0x28, 0x06, 0x0C, 0x01
// before the first READY. Without it, the block goes straight to READY.
//
// Ports:
//   Clock, Reset             : clock, synchronous active-high reset
//   iInitDone                : power-on init finished (level)
//   iReq, iRS, iData         : write request, register select, byte (sampled when oReady=1)
//   oReady, oConfigDone      : idle/accepting, configuration finished (sticky)
//   LCD_E, LCD_RS, LCD_RW    : LCD strobe, register select, read/write (tied to write)
//   SF_DATA                  : LCD DB7..DB4
//   oLCD_StrataFlashControl  : tied high to keep the shared StrataFlash disabled
module lcd_write_sequencer #(
  parameter int unsigned P_SETUP      = 2,
  parameter int unsigned P_E_HIGH     = 12,
  parameter int unsigned P_NIB_GAP    = 50,
  parameter int unsigned P_CMD_WAIT   = 2000,
  parameter int unsigned P_CLEAR_WAIT = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iInitDone,
  input  logic       iReq,
  input  logic       iRS,
  input  logic [7:0] iData,
  output logic       oReady,
  output logic       oConfigDone,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [3:0] SF_DATA,
  output logic       oLCD_StrataFlashControl
);

  typedef enum logic [3:0] {
    S_WAIT_INIT,
    S_CFG_LOAD,
    S_HI_SETUP,
    S_HI_PULSE,
    S_NIB_GAP,
    S_LO_SETUP,
    S_LO_PULSE,
    S_BYTE_WAIT,
    S_READY
  } state_t;

  state_t      state;
  logic [31:0] cnt;
  logic [31:0] dur;
  logic        last;
  logic [7:0]  byte_q;
  logic        rs_q;
  logic        long_wait;

  assign LCD_RW                  = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

  // Clear (0x01) and return-home (0x02) commands need the long execution wait.
  assign long_wait = !rs_q && (byte_q == 8'h01 || byte_q == 8'h02);

  always_comb begin
    dur = 32'd1;
    case (state)
      S_HI_SETUP, S_LO_SETUP: dur = P_SETUP;
      S_HI_PULSE, S_LO_PULSE: dur = P_E_HIGH;
      S_NIB_GAP:              dur = P_NIB_GAP;
      S_BYTE_WAIT:            dur = long_wait ? P_CLEAR_WAIT : P_CMD_WAIT;
      default:                dur = 32'd1;
    endcase
  end

  assign last = (cnt == dur - 32'd1);

`ifdef LCD_CONFIG_SEQ_EN
  logic [1:0] cfg_idx;

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_byte = 8'h28;  // function set: 4-bit, 2 lines
      2'd1:    cfg_byte = 8'h06;  // entry mode: increment, no shift
      2'd2:    cfg_byte = 8'h0C;  // display on, cursor off
      default: cfg_byte = 8'h01;  // clear display
    endcase
  endfunction
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= S_WAIT_INIT;
      cnt         <= 32'd0;
      byte_q      <= 8'h00;
      rs_q        <= 1'b0;
      oReady      <= 1'b0;
      oConfigDone <= 1'b0;
      LCD_E       <= 1'b0;
      LCD_RS      <= 1'b0;
      SF_DATA     <= 4'h0;
`ifdef LCD_CONFIG_SEQ_EN
      cfg_idx     <= 2'd0;
`endif
    end else begin
      // Timed states count up and clear on exit; every transition below clears cnt.
      cnt <= last ? 32'd0 : cnt + 32'd1;
      case (state)
        S_WAIT_INIT: begin
          cnt <= 32'd0;
          if (iInitDone) begin
`ifdef LCD_CONFIG_SEQ_EN
            state <= S_CFG_LOAD;
`else
            state       <= S_READY;
            oReady      <= 1'b1;
            oConfigDone <= 1'b1;
`endif
          end
        end
`ifdef LCD_CONFIG_SEQ_EN
        S_CFG_LOAD: begin
          cnt     <= 32'd0;
          byte_q  <= cfg_byte(cfg_idx);
          rs_q    <= 1'b0;
          SF_DATA <= cfg_byte(cfg_idx) >> 4;
          LCD_RS  <= 1'b0;
          LCD_E   <= 1'b0;
          state   <= S_HI_SETUP;
        end
`endif
        S_HI_SETUP: if (last) begin
          state <= S_HI_PULSE;
          LCD_E <= 1'b1;
        end
        S_HI_PULSE: if (last) begin
          state <= S_NIB_GAP;
          LCD_E <= 1'b0;
        end
        S_NIB_GAP: if (last) begin
          state   <= S_LO_SETUP;
          SF_DATA <= byte_q[3:0];
        end
        S_LO_SETUP: if (last) begin
          state <= S_LO_PULSE;
          LCD_E <= 1'b1;
        end
        S_LO_PULSE: if (last) begin
          state <= S_BYTE_WAIT;
          LCD_E <= 1'b0;
        end
        S_BYTE_WAIT: if (last) begin
`ifdef LCD_CONFIG_SEQ_EN
          // oConfigDone still low means this byte belongs to the config sequence.
          if (!oConfigDone && cfg_idx != 2'd3) begin
            cfg_idx <= cfg_idx + 2'd1;
            state   <= S_CFG_LOAD;
          end else begin
            state       <= S_READY;
            oReady      <= 1'b1;
            oConfigDone <= 1'b1;
          end
`else
          state       <= S_READY;
          oReady      <= 1'b1;
          oConfigDone <= 1'b1;
`endif
        end
        S_READY: begin
          cnt <= 32'd0;
          if (iReq) begin
            byte_q  <= iData;
            rs_q    <= iRS;
            SF_DATA <= iData[7:4];
            LCD_RS  <= iRS;
            oReady  <= 1'b0;
            state   <= S_HI_SETUP;
          end
        end
        default: begin
          state <= S_WAIT_INIT;
          cnt   <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/lcd_write_sequencer.md
Name: lcd_write_sequencer

Overview:
- Drives the 4-bit LCD bus after the power-on init controller asserts its done flag.
- Without the config sequence compiled in, it enters READY right after init done.
- Accepts byte writes (command or data) from upstream logic through a ready/request handshake.
- Splits each byte into high and low nibbles, generates the LCD_E pulse timing, and enforces the per-command execution wait.
- With LCD_CONFIG_SEQ_EN, it also runs the four-command post-init configuration before accepting writes.

Parameters:
- P_SETUP, 2, cycles SF_DATA/LCD_RS are stable before the LCD_E rise (40 ns at 50 MHz).
- P_E_HIGH, 12, cycles LCD_E is held high per nibble (240 ns).
- P_NIB_GAP, 50, cycles LCD_E is low between the high and low nibble (1 us).
- P_CMD_WAIT, 2000, cycles of wait after a normal byte (40 us).
- P_CLEAR_WAIT, 82000, cycles of wait after command 0x01 or 0x02 (1.64 ms).

Ports:
- Clock  in  1  system clock (50 MHz)
- Reset  in  1  synchronous, active-high reset
- iInitDone  in  1  power-on init complete (level; from init controller)
- iReq  in  1  write request; sampled only when oReady=1
- iRS  in  1  0=command, 1=data; captured with iReq
- iData  in  8  byte to write; captured with iReq
- oReady  out  1  sequencer idle, accepting a request
- oConfigDone  out  1  configuration sequence complete (sticky until Reset)
- LCD_E  out  1  LCD enable strobe
- LCD_RS  out  1  register select
- LCD_RW  out  1  constant 0 (write only)
- SF_DATA  out  4  LCD data nibble (DB7..DB4)
- oLCD_StrataFlashControl  out  1  constant 1 (StrataFlash disabled)

Behaviour:
- Single clock domain; all registers update on posedge Clock.
- Reset=1 for any cycle, including mid-transfer:
  - Outputs: LCD_E=0, LCD_RS=0, SF_DATA=0, oReady=0, oConfigDone=0.
  - Internal: config index=0, state=WAIT_INIT, cycle counter=0, request dropped.
- Cycle counter: 32-bit, cleared on every state entry. Each timed state lasts exactly its parameter count of cycles, then advances.
- States:
  - WAIT_INIT: all outputs low. Advances when iInitDone=1. Next state is CFG_LOAD if LCD_CONFIG_SEQ_EN is defined, else READY.
  - CFG_LOAD: loads the byte for the current config index with RS=0 (index 0..3 = 0x28, 0x06, 0x0C, 0x01), then goes to HI_SETUP. Duration 1 cycle.
  - HI_SETUP (P_SETUP): SF_DATA=byte[7:4], LCD_RS=captured RS, LCD_E=0.
  - HI_PULSE (P_E_HIGH): LCD_E=1; data and RS unchanged.
  - NIB_GAP (P_NIB_GAP): LCD_E=0; SF_DATA holds the high nibble.
  - LO_SETUP (P_SETUP): SF_DATA=byte[3:0], LCD_E=0.
  - LO_PULSE (P_E_HIGH): LCD_E=1.
  - BYTE_WAIT: LCD_E=0, SF_DATA holds the low nibble.
    - Duration is P_CLEAR_WAIT if RS=0 and byte is 0x01 or 0x02, else P_CMD_WAIT.
    - On exit, if in config: increment index; index<4 goes to CFG_LOAD, else set oConfigDone=1 and go to READY.
    - On exit, if not in config: go to READY.
  - READY: oReady=1, LCD_E=0. If iReq=1 in the same cycle, capture iRS/iData, drop oReady the next cycle, and go to HI_SETUP.
- Handshake:
  - iReq while oReady=0 is ignored; no queuing.
  - Upstream must hold iReq/iRS/iData valid in the cycle oReady=1 is sampled.
  - Accept-to-first-LCD_E-rise latency = 1 + P_SETUP cycles.
- Byte turnaround (accept to next oReady) = 1 + 2*P_SETUP + 2*P_E_HIGH + P_NIB_GAP + wait cycles. Defaults, normal byte: 1+4+24+50+2000 = 2079.
- iInitDone dropping after WAIT_INIT has no effect; only Reset returns the block to WAIT_INIT.
- Without the config sequence, oConfigDone=1 is set on entering READY.

Optional Feature:
- Macro: LCD_CONFIG_SEQ_EN.
- Defined: after iInitDone, the block automatically issues 0x28 (function set, 4-bit, 2 lines), 0x06 (entry mode), 0x0C (display on, cursor off), then 0x01 (clear, long wait). Then oConfigDone=1 and READY.
- Undefined: CFG_LOAD and the config index are not built. WAIT_INIT goes straight to READY, and upstream owns all configuration.

Test Plan:
- Reset held 5 cycles with iInitDone=1 -> every cycle: LCD_E=0, LCD_RS=0, SF_DATA=0, oReady=0, oConfigDone=0, LCD_RW=0, oLCD_StrataFlashControl=1.
- LCD_CONFIG_SEQ_EN, small parameters (P_SETUP=1, P_E_HIGH=2, P_NIB_GAP=3, P_CMD_WAIT=5, P_CLEAR_WAIT=9), iInitDone=1 -> eight LCD_E pulses of width 2 with SF_DATA 2,8,0,6,0,C,0,1 and RS=0. Wait after the last pulse is 9 cycles, then oConfigDone=1 and oReady=1.
- From READY, iReq=1, iRS=1, iData=0x41 -> oReady=0 next cycle. LCD_E rises 1+P_SETUP cycles after accept with SF_DATA=4, RS=1; second pulse has SF_DATA=1. oReady returns after exactly the turnaround formula (default 2079).
- Command iRS=0, iData=0x01 -> BYTE_WAIT lasts P_CLEAR_WAIT. Same with iRS=1, iData=0x01 -> lasts P_CMD_WAIT.
- iReq pulsed with 0x55 during NIB_GAP of a 0x41 write -> ignored. Exactly two LCD_E pulses occur, and no 5/5 nibbles appear.
- Reset asserted during HI_PULSE -> LCD_E=0 the next cycle and state is WAIT_INIT. After release with iInitDone=1, the sequence restarts from config index 0 (or READY without the macro).
